systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 138 +++++++++++++
 tb/tb_systolic_feeder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - tile sequencer and per-lane skew pipelines feeding an N x N systolic array
// Build option: define SYSTOLIC_FEEDER_ZERO_GATE_EN to force zero data into bubble slots.
module systolic_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [15:0]             k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  output logic [N*DATA_WIDTH-1:0] a_out,
  output logic [N*DATA_WIDTH-1:0] b_out,
  output logic [N-1:0]            en_out,
  output logic                    clr,
  output logic                    busy,
  output logic                    done
);

  localparam int            FW         = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             k_len_q, k_len_d;
  logic [15:0]             beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
  logic                    xfer;
  logic [N*DATA_WIDTH-1:0] a_load;
  logic [N*DATA_WIDTH-1:0] b_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    in_ready    = 1'b0;
    clr         = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d = k_len;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr         = 1'b1;
        beat_cnt_d  = '0;
        flush_cnt_d = '0;
        state_d     = (k_len_q != 16'd0) ? STREAM : FLUSH;
      end
      STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          // k_len_q is nonzero here, so k_len_q-1 cannot underflow
          if (beat_cnt_q == k_len_q - 16'd1) state_d = FLUSH;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLUSH_LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign xfer = in_ready & in_valid;

`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
  assign a_load = xfer ? in_a : '0;
  assign b_load = xfer ? in_b : '0;
`else
  assign a_load = in_a;
  assign b_load = in_b;
`endif

  // Lane i has i+1 stages so lane i lags lane 0 by exactly i cycles
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_q [0:i];
    logic [DATA_WIDTH-1:0] b_q [0:i];
    logic [i:0]            en_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q <= '0;
        for (int s = 0; s <= i; s++) begin
          a_q[s] <= '0;
          b_q[s] <= '0;
        end
      end else begin
        en_q[0] <= xfer;
        a_q[0]  <= a_load[i*DATA_WIDTH +: DATA_WIDTH];
        b_q[0]  <= b_load[i*DATA_WIDTH +: DATA_WIDTH];
        for (int s = 1; s <= i; s++) begin
          en_q[s] <= en_q[s-1];
          a_q[s]  <= a_q[s-1];
          b_q[s]  <= b_q[s-1];
        end
      end
    end

    assign en_out[i]                          = en_q[i];
    assign a_out[i*DATA_WIDTH +: DATA_WIDTH] = a_q[i];
    assign b_out[i*DATA_WIDTH +: DATA_WIDTH] = b_q[i];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed bench for systolic_feeder, N=4 DATA_WIDTH=8
module tb_systolic_feeder;
  localparam int DW = 8;
  localparam int N  = 4;

`ifdef SYSTOLIC_FEEDER_ZERO_GATE_EN
  localparam logic [7:0] BUB = 8'h00;
`else
  localparam logic [7:0] BUB = 8'hFF;
`endif

  // Per observed cycle: {busy, in_ready, clr, done, en_out[3:0]}
  localparam logic [7:0] T1 [0:12] = '{8'hA0, 8'hC0, 8'hC1, 8'hC3, 8'h87, 8'h8E, 8'h8C,
                                       8'h88, 8'h80, 8'h80, 8'h80, 8'h90, 8'h00};
  localparam logic [7:0] T2 [0:9]  = '{8'hA0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
                                       8'h80, 8'h90, 8'h00};
  localparam logic [7:0] T3 [0:16] = '{8'hA0, 8'hC0, 8'hC1, 8'hC2, 8'hC5, 8'hCA, 8'hC5,
                                       8'hCA, 8'h85, 8'h8A, 8'h84, 8'h88, 8'h80, 8'h80,
                                       8'h80, 8'h90, 8'h00};
  localparam logic [7:0] T4 [0:12] = '{8'hA0, 8'hC0, 8'hC1, 8'h83, 8'h86, 8'h8C, 8'h88,
                                       8'h80, 8'h80, 8'h80, 8'h90, 8'h00, 8'h00};

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              start    = 1'b0;
  logic [15:0]       k_len    = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   in_a     = '0;
  logic [N*DW-1:0]   in_b     = '0;
  logic [N*DW-1:0]   a_out;
  logic [N*DW-1:0]   b_out;
  logic [N-1:0]      en_out;
  logic              clr;
  logic              busy;
  logic              done;
  logic [7:0]        st;
  int                vectors     = 0;
  int                miscompares = 0;
  int                en_cnt [0:3];

  systolic_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .a_out    (a_out),
    .b_out    (b_out),
    .en_out   (en_out),
    .clr      (clr),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  assign st = {busy, in_ready, clr, done, en_out};

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_status", 0, {24'd0, st}, 32'd0);
    chk("rst_a_out", 0, a_out, 32'd0);
    chk("rst_b_out", 0, b_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_status", 0, {24'd0, st}, 32'd0);

    // k_len=3, continuous valid
    in_valid = 1'b1;
    in_b     = {4{8'd1}};
    start    = 1'b1;
    k_len    = 16'd3;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t1_status", c, {24'd0, st}, {24'd0, T1[c-1]});
      if (c == 3) chk("t1_a_lane0", c, {24'd0, a_out[7:0]}, 32'd1);
      if (c == 4) chk("t1_a_lane0", c, {24'd0, a_out[7:0]}, 32'd2);
      if (c == 6) chk("t1_a_lane3", c, {24'd0, a_out[31:24]}, 32'd1);
      if (c == 7) chk("t1_b_lane3", c, {24'd0, b_out[31:24]}, 32'd1);
      if (c == 8) chk("t1_a_lane3", c, {24'd0, a_out[31:24]}, 32'd3);
      if (c >= 2 && c <= 4) in_a = {4{8'(c - 1)}};
    end

    // k_len=0: clear then straight to flush
    in_valid = 1'b1;
    start    = 1'b1;
    k_len    = 16'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t2_status", c, {24'd0, st}, {24'd0, T2[c-1]});
    end

    // k_len=4, valid toggling, bubbles carry 0xFF input data
    in_valid = 1'b0;
    start    = 1'b1;
    k_len    = 16'd4;
    for (int l = 0; l < 4; l++) en_cnt[l] = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t3_status", c, {24'd0, st}, {24'd0, T3[c-1]});
      for (int l = 0; l < 4; l++) if (en_out[l]) en_cnt[l]++;
      if (c == 3) chk("t3_a_lane0", c, {24'd0, a_out[7:0]}, 32'h12);
      if (c == 4) chk("t3_bub_a_lane0", c, {24'd0, a_out[7:0]}, {24'd0, BUB});
      if (c == 6) chk("t3_a_lane3", c, {24'd0, a_out[31:24]}, 32'h12);
      if (c == 7) chk("t3_bub_a_lane3", c, {24'd0, a_out[31:24]}, {24'd0, BUB});
      if (c == 7) chk("t3_bub_b_lane3", c, {24'd0, b_out[31:24]}, {24'd0, BUB});
      in_valid = (c >= 2 && c <= 8) ? ((c % 2) == 0) : 1'b0;
      in_a     = in_valid ? {4{8'(8'h10 + c)}} : {4{8'hFF}};
      in_b     = in_valid ? {4{8'(8'h20 + c)}} : {4{8'hFF}};
    end
    for (int l = 0; l < 4; l++) chk("t3_en_pulses", l, en_cnt[l], 32'd4);

    // start during STREAM (with a different k_len) and during DONE is ignored
    in_valid = 1'b1;
    start    = 1'b1;
    k_len    = 16'd2;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t4_status", c, {24'd0, st}, {24'd0, T4[c-1]});
      if (c == 2) begin
        start = 1'b1;
        k_len = 16'd5;
      end
      if (c == 11) start = 1'b1;
    end

    // reset in third STREAM cycle, then a clean k_len=2 tile
    in_valid = 1'b1;
    start    = 1'b1;
    k_len    = 16'd5;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t5_pre_reset", 4, {24'd0, st}, 32'hC3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_status", 4, {24'd0, st}, 32'd0);
    chk("t5_rst_a_out", 4, a_out, 32'd0);
    chk("t5_rst_b_out", 4, b_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t5_after_release", c, {24'd0, st}, 32'd0);
    end
    start = 1'b1;
    k_len = 16'd2;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t5_restart_status", c, {24'd0, st}, {24'd0, T4[c-1]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
